operand_b_pipe: RTL and testbench
=================================

# operand_b_pipe

Parametrised, registered successor to the ALU operand-B source multiplexer of the processing unit. Selects one of NUM_SRC data sources or a built-in constant according to a selector code, and presents the result through a valid/ready pipeline stage, so the ALU input path can be stalled without losing operands. Sits between the register file / sign-extend / shift / MDR outputs and ALU input B. Also counts illegal selector codes for debug.

## Interface
Parameters:
- WIDTH, 32, data width of each source and of the output
- NUM_SRC, 4, number of external sources (minimum 1)
- CONST_VAL, 4, constant returned for selector code 1 (truncated to WIDTH)
- SEL_W, $clog2(NUM_SRC+1) with a minimum of 1, selector width (derived; do not override)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers a beat
- in_ready  output  1  stage accepts a beat this cycle
- sel  input  SEL_W  source code, sampled with the beat
- src  input  NUM_SRC*WIDTH  packed sources; src[0] occupies bits WIDTH-1:0
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream consumes the beat
- out_data  output  WIDTH  selected operand
- out_sel_err  output  1  the current output beat came from an illegal code
- err_count  output  8  saturating count of accepted illegal codes

## Operation
- Decode, applied at acceptance (in_valid && in_ready):
  - code 0 gives src[0].
  - code 1 gives CONST_VAL.
  - code k, for 2 ≤ k ≤ NUM_SRC, gives src[k-1].
  - Any code above NUM_SRC gives src[0] with the beat's err flag set to 1.
- With the defaults, codes 0–4 give src[0], 4, src[1], src[2], src[3]. This is the legacy mapping rt, 4, offset, mdr, desloc, with undefined codes falling back to rt.
- The selected value and its err flag travel together. out_sel_err is valid only while out_valid=1.
- A beat transfers downstream when out_valid && out_ready.
- out_data and out_sel_err stay stable while out_valid=1 and out_ready=0.
- err_count increments by 1 per accepted illegal beat and saturates at 255. The increment is counted at acceptance, not at output.
- No beat is dropped or duplicated. Beats leave in acceptance order.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel_err=0, err_count=0. in_ready=0 while reset=1.
- The first acceptance is possible in the cycle after reset deasserts.
- Reset asserted mid-operation discards every buffered beat on the next edge.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N. That is one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous accept and drain in the same cycle is legal. The new beat replaces the drained one with no bubble.
- Sources and sel are don't-care when in_valid=0.

## Configuration
- Macro OPERAND_B_PIPE_SKID_EN.
- Defined: a 2-entry skid buffer.
  - in_ready is a registered output with no combinational path from out_ready.
  - When out_ready drops, one extra in-flight beat is absorbed into the skid entry.
  - in_ready falls only when both entries are full and rises the cycle after an entry frees.
- Undefined: a single output register with in_ready = !out_valid || out_ready, which is combinational from out_ready (forced 0 during reset).
- Both builds share the same decode, latency, reset values and err_count behaviour.

## Structure
- Shared package operand_pkg holds:
  - the select-code constants: SEL_SRC0=0, SEL_CONST=1, SEL_SRC_BASE=2;
  - the legacy default CONST_VAL=4;
  - ERRCNT_W=8.
- One sub-module, operand_skid_buffer.
  - It is a generic WIDTH+1-bit valid/ready register that carries data plus the err flag.
  - It is instantiated in either mode, with the skid entry enabled under the macro.
- The decode and err_count logic live in the top module.

## Test plan
- Reset with in_valid=1 → in_ready=0, out_valid=0, out_data=0, err_count=0 throughout reset. First accept occurs one cycle after deassert.
- Defaults, out_ready=1, src={0x44,0x33,0x22,0x11} (src[3] down to src[0]), sel=0,1,2,3,4 on consecutive cycles → out_data 0x11, 0x4, 0x22, 0x33, 0x44. Each appears one cycle after its sel, with no bubbles.
- sel=5, 6, 7 with src[0]=0xAA → out_data=0xAA each time, out_sel_err=1, err_count=3. Then 260 illegal beats → err_count=255, held.
- Stream 8 beats while holding out_ready=0 for cycles 3–6 → output holds the same beat while stalled. All 8 values emerge in order, none lost.
  - With OPERAND_B_PIPE_SKID_EN: in_ready drops exactly one cycle after the stall begins.
- reset pulsed while a beat is held (out_valid=1, out_ready=0) → next cycle out_valid=0, out_data=0. The held beat never appears.
- Parameter sweep NUM_SRC=1 (SEL_W=1) and NUM_SRC=7 (SEL_W=3), WIDTH=16, CONST_VAL=0x1_0004 → decode follows the code rule. The constant reads 0x0004 (truncated). With NUM_SRC=7, code 7 is legal and gives src[6].

Source files
------------

// File: rtl/operand_pkg.sv
// Shared constants for the ALU operand-B source pipeline.
// Select codes keep the legacy mapping: 0 -> src[0], 1 -> constant,
// 2.. -> src[1].. ; anything above the source count is illegal.
package operand_pkg;

  localparam int SEL_SRC0     = 0;
  localparam int SEL_CONST    = 1;
  localparam int SEL_SRC_BASE = 2;

  // Legacy built-in constant (the "+4" operand).
  localparam int unsigned DEF_CONST_VAL = 4;

  localparam int ERRCNT_W = 8;

  // Selector width: enough bits for codes 0..num_src, never below 1.
  function automatic int sel_width(input int num_src);
    int w;
    w = $clog2(num_src + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/operand_skid_buffer.sv
// Generic valid/ready register stage carrying DW bits.
// SKID_EN=0: single register, in_ready = !out_valid || out_ready.
// SKID_EN=1: main + skid entry, in_ready driven from flop state only, so the
//            out_ready -> in_ready path is broken; one in-flight beat lands in
//            the skid entry when the consumer stalls.
module operand_skid_buffer #(
  parameter int DW      = 33,
  parameter bit SKID_EN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_vld_q, main_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          main_free;
  logic          accept;

  // Handshake and next-state: skid drains first so ordering is preserved.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    main_free  = !main_vld_q || out_ready;
    if (SKID_EN) in_ready = !reset && !skid_vld_q;
    else         in_ready = !reset && main_free;
    accept = in_valid && in_ready;

    if (main_free) begin
      if (skid_vld_q) begin
        // in_ready was low, so no new beat competes this cycle.
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_data;
      end
    end else if (accept) begin
      // Only reachable with the skid entry enabled.
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  // State registers; reset discards every buffered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_q;

endmodule

// File: rtl/operand_b_pipe.sv
// ALU operand-B source select with a registered valid/ready output stage.
// Decodes sel at acceptance, carries an illegal-code flag with each beat and
// keeps a saturating count of accepted illegal codes.
// Build option: define OPERAND_B_PIPE_SKID_EN for a 2-entry skid buffer with
// a registered in_ready; otherwise a single register stage is used.
module operand_b_pipe
  import operand_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          NUM_SRC   = 4,
  parameter int unsigned CONST_VAL = DEF_CONST_VAL,
  parameter int          SEL_W     = sel_width(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic [ERRCNT_W-1:0]      err_count
);

`ifdef OPERAND_B_PIPE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0]    CONST_W = WIDTH'(CONST_VAL);
  localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0]    dec_data;
  logic                dec_err;
  int                  sel_i;
  logic                accept;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH:0]      buf_out;

  // Source decode; illegal codes fall back to src[0] and raise the flag.
  always_comb begin
    sel_i    = int'(sel);
    dec_data = src[WIDTH-1:0];
    dec_err  = 1'b0;
    if (sel_i == SEL_SRC0) begin
      dec_data = src[WIDTH-1:0];
    end else if (sel_i == SEL_CONST) begin
      dec_data = CONST_W;
    end else if (sel_i <= NUM_SRC) begin
      for (int k = SEL_SRC_BASE; k <= NUM_SRC; k++)
        if (sel_i == k) dec_data = src[(k-1)*WIDTH +: WIDTH];
    end else begin
      dec_err = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  // Illegal-code counter, bumped at acceptance and pinned at its maximum.
  always_comb begin
    err_count_d = err_count_q;
    if (accept && dec_err && (err_count_q != ERR_MAX))
      err_count_d = err_count_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  operand_skid_buffer #(
    .DW      (WIDTH + 1),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({dec_err, dec_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data    = buf_out[WIDTH-1:0];
  assign out_sel_err = buf_out[WIDTH];
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_operand_b_pipe.sv
// Self-checking bench for operand_b_pipe: default instance checked through a
// scoreboard, plus two parameter-sweep instances checked directly.
module tb_operand_b_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, out_ready;
  logic [2:0]   sel;
  logic [127:0] src;
  logic         in_ready, out_valid, out_sel_err;
  logic [31:0]  out_data;
  logic [7:0]   err_count;

  // sweep instances
  logic [0:0]   sel1;
  logic [15:0]  src1;
  logic         in_ready1, out_valid1, out_sel_err1;
  logic [15:0]  out_data1;
  logic [7:0]   err_count1;
  logic [2:0]   sel2;
  logic [111:0] src2;
  logic         in_ready2, out_valid2, out_sel_err2;
  logic [15:0]  out_data2;
  logic [7:0]   err_count2;

  beat_t sb[$];
  int    checks = 0;
  int    fails  = 0;

  always #5 clk = ~clk;

  operand_b_pipe u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src(src), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel_err(out_sel_err), .err_count(err_count)
  );

  operand_b_pipe #(.WIDTH(16), .NUM_SRC(1), .CONST_VAL(32'h0001_0004)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .sel(sel1), .src(src1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sel_err(out_sel_err1), .err_count(err_count1)
  );

  operand_b_pipe #(.WIDTH(16), .NUM_SRC(7), .CONST_VAL(32'h0001_0004)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .sel(sel2), .src(src2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sel_err(out_sel_err2), .err_count(err_count2)
  );

  // Reference decode for the default instance (32-bit, 4 sources, const 4).
  function automatic beat_t model(input int s, input logic [127:0] sv);
    beat_t b;
    b.d = sv[31:0];
    b.e = 1'b0;
    if (s == 1)                b.d = 32'd4;
    else if (s >= 2 && s <= 4) b.d = sv[(s-1)*32 +: 32];
    else if (s > 4)            b.e = 1'b1;
    return b;
  endfunction

  // One clock: sample handshakes, update scoreboard, advance to next negedge.
  task automatic cyc(output bit acc, output bit drn, output bit vld,
                     output beat_t got, output beat_t exp, output bit had);
    #1;
    acc   = in_valid && in_ready;
    drn   = out_valid && out_ready;
    vld   = out_valid;
    got.d = out_data;
    got.e = out_sel_err;
    had   = 1'b0;
    exp   = '0;
    if (drn && sb.size() > 0) begin
      had = 1'b1;
      exp = sb.pop_front();
    end
    if (acc) sb.push_back(model(int'(sel), src));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit acc, drn, vld, had;
    beat_t got, exp;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 3'd0;
    src = {32'h44, 32'h33, 32'h22, 32'h11};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || err_count !== 8'h0) begin
        fails++;
        $display("FAIL reset_state rdy=%b vld=%b data=%h cnt=%h want 0/0/0/0",
                 in_ready, out_valid, out_data, err_count);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    cyc(acc, drn, vld, got, exp, had);
    checks++;
    if (acc !== 1'b1) begin
      fails++; $display("FAIL first_accept acc=%b want 1", acc);
    end
    cyc(acc, drn, vld, got, exp, had);
    checks++;
    if (!drn || !had || got !== exp) begin
      fails++; $display("FAIL first_beat drn=%b got=%h want=%h", drn, got, exp);
    end
  endtask

  task automatic test_decode();
    bit acc, drn, vld, had;
    beat_t got, exp;
    logic [31:0] tab [5];
    tab[0] = 32'h11; tab[1] = 32'h4; tab[2] = 32'h22; tab[3] = 32'h33; tab[4] = 32'h44;
    out_ready = 1'b1;
    src = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 5);
      sel = 3'(i);
      cyc(acc, drn, vld, got, exp, had);
      if (i >= 1 && i <= 5) begin
        checks++;
        if (!drn || got.d !== tab[i-1] || got.e !== 1'b0 || got !== exp) begin
          fails++;
          $display("FAIL decode_%0d drn=%b got=%h want=%h", i - 1, drn, got.d, tab[i-1]);
        end
      end
    end
  endtask

  task automatic test_err_count();
    bit acc, drn, vld, had;
    beat_t got, exp;
    out_ready = 1'b1;
    src = {32'h44, 32'h33, 32'h22, 32'hAA};
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      sel = 3'(5 + i);
      cyc(acc, drn, vld, got, exp, had);
      if (drn) begin
        checks++;
        if (!had || got.d !== 32'hAA || got.e !== 1'b1 || got !== exp) begin
          fails++; $display("FAIL err_beat got=%h/%b want=000000aa/1", got.d, got.e);
        end
      end
    end
    #1;
    checks++;
    if (err_count !== 8'd3) begin
      fails++; $display("FAIL err_count3 got=%0d want=3", err_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      sel = 3'(5 + (i % 3));
      cyc(acc, drn, vld, got, exp, had);
      if (drn) begin
        checks++;
        if (!had || got !== exp) begin
          fails++; $display("FAIL err_stream got=%h want=%h", got, exp);
        end
      end
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (err_count !== 8'd255) begin
      fails++; $display("FAIL err_sat got=%0d want=255", err_count);
    end
    cyc(acc, drn, vld, got, exp, had);
    cyc(acc, drn, vld, got, exp, had);
    #1;
    checks++;
    if (err_count !== 8'd255 || sb.size() != 0) begin
      fails++; $display("FAIL err_hold got=%0d want=255 pending=%0d", err_count, sb.size());
    end
  endtask

  task automatic test_stall();
    bit acc, drn, vld, had, prev_hold;
    beat_t got, exp;
    logic [31:0] prev_d;
    int k, drains;
    k = 0; drains = 0; prev_hold = 1'b0; prev_d = '0;
    sel = 3'd2;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (k < 8);
      src = {32'h44, 32'h33, 32'h100 + 32'(k), 32'h11};
      cyc(acc, drn, vld, got, exp, had);
      if (acc) k++;
      if (prev_hold) begin
        checks++;
        if (got.d !== prev_d) begin
          fails++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, got.d, prev_d);
        end
      end
      prev_hold = vld && !out_ready;
      prev_d    = got.d;
`ifdef OPERAND_B_PIPE_SKID_EN
      if (c == 3 || c == 4) begin
        checks++;
        if (acc !== (c == 3)) begin
          fails++; $display("FAIL skid_ready c=%0d acc=%b want=%b", c, acc, (c == 3));
        end
      end
`else
      if (c == 3) begin
        checks++;
        if (acc !== 1'b0) begin
          fails++; $display("FAIL stall_ready acc=%b want 0", acc);
        end
      end
`endif
      if (drn) begin
        drains++;
        checks++;
        if (!had || got !== exp || got.d !== 32'h100 + 32'(drains - 1)) begin
          fails++; $display("FAIL stall_order got=%h want=%h", got.d, 32'h100 + 32'(drains - 1));
        end
      end
    end
    checks++;
    if (drains != 8 || sb.size() != 0) begin
      fails++; $display("FAIL stall_count got=%0d want=8 pending=%0d", drains, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc, drn, vld, had;
    beat_t got, exp;
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
    src = {32'h44, 32'h33, 32'h22, 32'h5A5};
    cyc(acc, drn, vld, got, exp, had);
    in_valid = 1'b0;
    cyc(acc, drn, vld, got, exp, had);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5A5) begin
      fails++; $display("FAIL held_beat vld=%b data=%h want 1/5a5", out_valid, out_data);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel_err !== 1'b0) begin
      fails++; $display("FAIL mid_reset vld=%b data=%h want 0/0", out_valid, out_data);
    end
    sb.delete();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(acc, drn, vld, got, exp, had);
      checks++;
      if (drn) begin
        fails++; $display("FAIL ghost_beat got=%h want none", got.d);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] exp1, exp2;
    logic [2:0]  iv;
    out_ready = 1'b1; in_valid = 1'b1;
    src1 = 16'hBEEF;
    for (int j = 0; j < 7; j++) src2[j*16 +: 16] = 16'h1000 + 16'(j);
    for (int i = 0; i < 8; i++) begin
      iv   = 3'(i);
      sel2 = iv;
      sel1 = iv[0];
      exp1 = iv[0] ? 16'h0004 : 16'hBEEF;
      exp2 = (i == 0) ? 16'h1000 : (i == 1) ? 16'h0004 : 16'h1000 + 16'(i - 1);
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== exp1 || out_sel_err1 !== 1'b0) begin
        fails++; $display("FAIL n1_code%0d got=%h want=%h", iv[0], out_data1, exp1);
      end
      checks++;
      if (out_valid2 !== 1'b1 || out_data2 !== exp2 || out_sel_err2 !== 1'b0) begin
        fails++; $display("FAIL n7_code%0d got=%h want=%h", i, out_data2, exp2);
      end
    end
    checks++;
    if (err_count2 !== 8'd0 || err_count1 !== 8'd0) begin
      fails++; $display("FAIL sweep_errcnt got=%0d/%0d want=0/0", err_count1, err_count2);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    sel1 = 1'b0; src1 = '0; sel2 = 3'd0; src2 = '0;
    test_reset();
    test_decode();
    test_err_count();
    test_stall();
    test_reset_mid();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
